// File: rtl/ftdi_245fifo_device_emu_if.sv
// Signal bundle between the emulated FT232H and its surroundings: the
// FTDI-side control strobes/flags plus the host-side AXI-stream byte ports.
// The shared ftdi_data bus is kept as a plain inout on the emulator.
//
// Handshakes: a host stream byte transfers on a rising edge where tvalid and
// tready are both high; tvalid/tdata hold until accepted. FTDI strobes are
// active-low and sampled on every rising clk edge.
interface ftdi_245fifo_device_emu_if;
   logic       ftdi_rxf_n;
   logic       ftdi_txe_n;
   logic       ftdi_oe_n;
   logic       ftdi_rd_n;
   logic       ftdi_wr_n;
   logic       host_in_tvalid;
   logic       host_in_tready;
   logic [7:0] host_in_tdata;
   logic       host_out_tvalid;
   logic       host_out_tready;
   logic [7:0] host_out_tdata;

   // Environment side: FPGA controller strobes plus the USB host.
   modport master (
      input  ftdi_rxf_n, ftdi_txe_n, host_in_tready, host_out_tvalid, host_out_tdata,
      output ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, host_in_tvalid, host_in_tdata, host_out_tready
   );

   // Emulated chip side.
   modport slave (
      input  ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, host_in_tvalid, host_in_tdata, host_out_tready,
      output ftdi_rxf_n, ftdi_txe_n, host_in_tready, host_out_tvalid, host_out_tdata
   );
endinterface

// File: rtl/ftdi_245fifo_device_emu.sv
// FT232H 245 synchronous-FIFO chip-side emulator. An RX buffer (host -> FPGA)
// is read over the shared bus with OE#/RD#, a TX buffer (FPGA -> host) is
// written with WR#. Everything runs on the emulated CLKOUT rising edge.
module ftdi_245fifo_device_emu #(
   parameter int RX_EA = 4,
   parameter int TX_EA = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   ftdi_245fifo_device_emu_if.slave  bus,
   inout  wire  [7:0]                ftdi_data,
   output logic                      protocol_err
);

   localparam int RX_DEPTH = 1 << RX_EA;
   localparam int TX_DEPTH = 1 << TX_EA;
   localparam logic [RX_EA:0] RX_FULL = {1'b1, {RX_EA{1'b0}}};
   localparam logic [TX_EA:0] TX_FULL = {1'b1, {TX_EA{1'b0}}};

   logic [7:0]       rx_mem_q [RX_DEPTH];
   logic [RX_EA-1:0] rx_wptr_q, rx_wptr_d;
   logic [RX_EA-1:0] rx_rptr_q, rx_rptr_d;
   logic [RX_EA:0]   rx_count_q, rx_count_d;

   logic [7:0]       tx_mem_q [TX_DEPTH];
   logic [TX_EA-1:0] tx_wptr_q, tx_wptr_d;
   logic [TX_EA-1:0] tx_rptr_q, tx_rptr_d;
   logic [TX_EA:0]   tx_count_q, tx_count_d;

   logic rxf_n_q, rxf_n_d;
   logic txe_n_q, txe_n_d;
   logic drv_q, drv_d;
   logic perr_q, perr_d;

   logic rx_push, rx_pop, tx_push, tx_pop;
   logic host_in_tready_w;
   logic bus_drive;

   // Host may push whenever the registered count is below full; a pop in the
   // same cycle does not open a slot early. Held off while in reset.
   assign host_in_tready_w = (rx_count_q != RX_FULL) && !rst;
   assign rx_push = bus.host_in_tvalid && host_in_tready_w;
   // rxf_n_q low already implies a non-empty buffer.
   assign rx_pop  = !bus.ftdi_oe_n && !bus.ftdi_rd_n && !rxf_n_q && drv_q;
   assign tx_push = !bus.ftdi_wr_n && !txe_n_q && bus.ftdi_oe_n;
   assign tx_pop  = (tx_count_q != '0) && bus.host_out_tready;

   // Bus is turned around one cycle after OE# falls, released as soon as it rises.
   assign bus_drive = drv_q && !bus.ftdi_oe_n;
   assign ftdi_data = bus_drive ? rx_mem_q[rx_rptr_q] : 8'hzz;

   assign bus.ftdi_rxf_n      = rxf_n_q;
   assign bus.ftdi_txe_n      = txe_n_q;
   assign bus.host_in_tready  = host_in_tready_w;
   assign bus.host_out_tvalid = (tx_count_q != '0);
   assign bus.host_out_tdata  = tx_mem_q[tx_rptr_q];
   assign protocol_err        = perr_q;

   // Next-state for pointers, counts, flags and the sticky error.
   always_comb begin
      rx_wptr_d  = rx_wptr_q;
      rx_rptr_d  = rx_rptr_q;
      rx_count_d = rx_count_q;
      tx_wptr_d  = tx_wptr_q;
      tx_rptr_d  = tx_rptr_q;
      tx_count_d = tx_count_q;

      if (rx_push) rx_wptr_d = rx_wptr_q + RX_EA'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + RX_EA'(1);
      case ({rx_push, rx_pop})
         2'b10:   rx_count_d = rx_count_q + (RX_EA+1)'(1);
         2'b01:   rx_count_d = rx_count_q - (RX_EA+1)'(1);
         default: rx_count_d = rx_count_q;
      endcase

      if (tx_push) tx_wptr_d = tx_wptr_q + TX_EA'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_EA'(1);
      case ({tx_push, tx_pop})
         2'b10:   tx_count_d = tx_count_q + (TX_EA+1)'(1);
         2'b01:   tx_count_d = tx_count_q - (TX_EA+1)'(1);
         default: tx_count_d = tx_count_q;
      endcase

      rxf_n_d = (rx_count_d == '0);
      txe_n_d = (tx_count_d == TX_FULL);
      drv_d   = !bus.ftdi_oe_n;
      perr_d  = perr_q
              | (!bus.ftdi_rd_n && bus.ftdi_oe_n)
              | (!bus.ftdi_wr_n && !bus.ftdi_oe_n)
              | (!bus.ftdi_rd_n && !bus.ftdi_wr_n);
   end

   // Control state with synchronous reset; reset flushes both buffers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         rx_count_q <= '0;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         tx_count_q <= '0;
         rxf_n_q    <= 1'b1;
         txe_n_q    <= 1'b1;
         drv_q      <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         rx_count_q <= rx_count_d;
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         tx_count_q <= tx_count_d;
         rxf_n_q    <= rxf_n_d;
         txe_n_q    <= txe_n_d;
         drv_q      <= drv_d;
         perr_q     <= perr_d;
      end
   end

   // Buffer storage; contents need no reset since counts gate visibility.
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wptr_q] <= bus.host_in_tdata;
      if (tx_push) tx_mem_q[tx_wptr_q] <= ftdi_data;
   end

endmodule
